// File: rtl/smitrv_pkg.sv
// Shared fetch-path definitions: data width, instruction alignment and the
// response word carried through the responder pipeline and queue.
package smitrv_pkg;

    localparam int XLEN             = 32;
    localparam int INSTR_ALIGN_BITS = 2;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic            err;
    } fetch_rsp_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head, used as the response queue.
// Writes when full and reads when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = do_wr ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_rd ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    // Pointer and occupancy registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts fetch requests, reads the word RAM, and
// returns responses in order after a fixed latency, with a credit-limited
// response queue absorbing backpressure. Includes a program-load write port.
module imem_responder
    import smitrv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int QDEPTH      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int LO    = INSTR_ALIGN_BITS;

    logic [XLEN-1:0]  mem_q [DEPTH_WORDS];

    logic             accept, rsp_fire;
    logic [IDX_W-1:0] req_idx, wr_idx;
    logic             req_err, wr_ok;
    fetch_rsp_t       stage_in;

    logic [LATENCY-1:0] pv_q;
    fetch_rsp_t         pd_q [LATENCY];
    fetch_rsp_t         pipe_out;
    logic               pipe_vld;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             fifo_push, fifo_pop, fifo_empty;
    logic [XLEN:0]    fifo_head_raw;
    fetch_rsp_t       fifo_head, out_rsp;
    logic             out_vld;
    logic [CNT_W-1:0] unused_fifo_count;
    logic             unused_fifo_full;

    // Out-of-range means any address bit above the RAM index is set.
    assign req_idx = req_addr[IDX_W+LO-1:LO];
    assign req_err = (req_addr[LO-1:0] != '0) || (req_addr[XLEN-1:IDX_W+LO] != '0);
    assign wr_idx  = wr_addr[IDX_W+LO-1:LO];
    assign wr_ok   = (wr_addr[LO-1:0] == '0) && (wr_addr[XLEN-1:IDX_W+LO] == '0);

    // Ready depends only on the credit register and reset, never on valid/ready inputs.
    assign req_ready = (cnt_q < CNT_W'(QDEPTH)) && !reset;
    assign accept    = req_valid && req_ready;

    // Stage-1 payload: RAM word for good fetches, zero data with err otherwise.
    always_comb begin
        stage_in      = '0;
        stage_in.err  = req_err;
        if (!req_err) stage_in.data = mem_q[req_idx];
    end

    // Program-load writes; RAM is not reset. Same-edge reads see the old word.
    always_ff @(posedge clk) begin
        if (wr_en && wr_ok) mem_q[wr_idx] <= wr_data;
    end

    // Valid bits of the latency chain; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= accept;
            for (int i = 1; i < LATENCY; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    // Payload of the latency chain: RAM read registers in stage 1, then pure delay.
    always_ff @(posedge clk) begin
        if (accept) pd_q[0] <= stage_in;
        for (int i = 1; i < LATENCY; i++) pd_q[i] <= pd_q[i-1];
    end

    assign pipe_out = pd_q[LATENCY-1];
    assign pipe_vld = pv_q[LATENCY-1];

    // Head selection: queued responses go first; with an empty queue the chain
    // output is presented directly and only queued if the consumer stalls.
    always_comb begin
        out_rsp   = pipe_out;
        out_vld   = pipe_vld;
        fifo_push = pipe_vld && !(fifo_empty && rsp_ready);
        fifo_pop  = !fifo_empty && rsp_ready;
        if (!fifo_empty) begin
            out_rsp = fifo_head;
            out_vld = 1'b1;
        end
    end

    assign fifo_head = fetch_rsp_t'(fifo_head_raw);
    assign rsp_valid = out_vld && !reset;
    assign rsp_data  = rsp_valid ? out_rsp.data : '0;
    assign rsp_err   = rsp_valid ? out_rsp.err  : 1'b0;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Credit count of requests accepted but not yet handed to the consumer.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(accept) - CNT_W'(rsp_fire);
    end

    // Credit register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    sync_fifo #(
        .WIDTH (XLEN + 1),
        .DEPTH (QDEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_push),
        .wr_data (pipe_out),
        .rd_en   (fifo_pop),
        .rd_data (fifo_head_raw),
        .count   (unused_fifo_count),
        .full    (unused_fifo_full),
        .empty   (fifo_empty)
    );

endmodule
